// File: rtl/edge_event_arbiter.sv
// rtl/edge_event_arbiter.sv - dual-edge detector with per-channel pending events and round-robin valid/ready delivery
module edge_event_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     level,
    input  logic [N-1:0]     rise_en,
    input  logic [N-1:0]     fall_en,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [IDX_W-1:0] evt_ch,
    output logic             evt_rise,
    output logic [N-1:0]     overrun,
    input  logic             clr_overrun
);

    typedef enum logic {IDLE, OFFER} state_t;

    state_t           state, state_next;
    logic [N-1:0]     level_q, pend_r, pend_f, ord;
    logic [IDX_W-1:0] ptr;

    logic             hs;
    logic [N-1:0]     rise, fall, served_r, served_f, keep_r, keep_f;
    logic [N-1:0]     pend_r_next, pend_f_next, ord_next, ovr_set;
    logic             found, sel_rise, load;
    logic [IDX_W-1:0] sel_ch;
    int               j;

    assign hs   = evt_valid & evt_ready;
    assign rise = level & ~level_q & rise_en;
    assign fall = ~level & level_q & fall_en;

    // ord[i] = 1 means the pending rise is older than the pending fall
    always_comb begin
        served_r    = '0;
        served_f    = '0;
        keep_r      = '0;
        keep_f      = '0;
        pend_r_next = '0;
        pend_f_next = '0;
        ord_next    = ord;
        ovr_set     = '0;
        for (int i = 0; i < N; i++) begin
            served_r[i]    = hs && evt_rise && (evt_ch == IDX_W'(i));
            served_f[i]    = hs && !evt_rise && (evt_ch == IDX_W'(i));
            keep_r[i]      = pend_r[i] & ~served_r[i];
            keep_f[i]      = pend_f[i] & ~served_f[i];
            pend_r_next[i] = keep_r[i] | rise[i];
            pend_f_next[i] = keep_f[i] | fall[i];
            ovr_set[i]     = (rise[i] & keep_r[i]) | (fall[i] & keep_f[i]);
            if (keep_r[i] && !keep_f[i] && fall[i])
                ord_next[i] = 1'b1;
            else if (keep_f[i] && !keep_r[i] && rise[i])
                ord_next[i] = 1'b0;
        end
    end

    // round-robin scan starting at ptr
    always_comb begin
        found    = 1'b0;
        sel_ch   = '0;
        sel_rise = 1'b0;
        j        = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!found && (pend_r[j] || pend_f[j])) begin
                found    = 1'b1;
                sel_ch   = IDX_W'(j);
                sel_rise = pend_r[j] & (~pend_f[j] | ord[j]);
            end
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    state_next = OFFER;
                    load       = 1'b1;
                end
            end
            OFFER: begin
                if (evt_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            level_q   <= '0;
            pend_r    <= '0;
            pend_f    <= '0;
            ord       <= '0;
            overrun   <= '0;
            ptr       <= '0;
            evt_valid <= 1'b0;
            evt_ch    <= '0;
            evt_rise  <= 1'b0;
        end else begin
            state   <= state_next;
            level_q <= level;
            pend_r  <= pend_r_next;
            pend_f  <= pend_f_next;
            ord     <= ord_next;
            overrun <= (clr_overrun ? '0 : overrun) | ovr_set;
            if (load) begin
                evt_valid <= 1'b1;
                evt_ch    <= sel_ch;
                evt_rise  <= sel_rise;
            end else if (hs) begin
                evt_valid <= 1'b0;
                ptr       <= (evt_ch == IDX_W'(N - 1)) ? '0 : evt_ch + IDX_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// tb/tb_edge_event_arbiter.sv - directed self-checking bench for edge_event_arbiter
module tb_edge_event_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] level;
    logic [3:0] rise_en;
    logic [3:0] fall_en;
    logic       evt_valid;
    logic       evt_ready;
    logic [1:0] evt_ch;
    logic       evt_rise;
    logic [3:0] overrun;
    logic       clr_overrun;

    int tests = 0;
    int fails = 0;

    edge_event_arbiter #(.N(4), .IDX_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .level(level), .rise_en(rise_en), .fall_en(fall_en),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_ch(evt_ch), .evt_rise(evt_rise),
        .overrun(overrun), .clr_overrun(clr_overrun)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; level = 4'b0001; rise_en = 4'hF; fall_en = 4'hF;
        evt_ready = 1'b0; clr_overrun = 1'b0;
        cyc(2);
        tests++; if (evt_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", evt_valid); end
        tests++; if (overrun !== 4'b0000) begin fails++; $display("FAIL reset_overrun got %b exp 0000", overrun); end
        rst_n = 1'b1;
        cyc(1);
        tests++; if (evt_valid !== 1'b0) begin fails++; $display("FAIL reset_first_cycle got %b exp 0", evt_valid); end
        cyc(1);
        tests++; if ({evt_valid, evt_ch, evt_rise} !== {1'b1, 2'd0, 1'b1})
            begin fails++; $display("FAIL reset_high_level got v%b ch%0d r%b exp v1 ch0 r1", evt_valid, evt_ch, evt_rise); end
        evt_ready = 1'b1;
        cyc(1);
        tests++; if (evt_valid !== 1'b0) begin fails++; $display("FAIL reset_accept got %b exp 0", evt_valid); end
        evt_ready = 1'b0; fall_en = 4'b1110; level = 4'b0000;
        cyc(1);
        fall_en = 4'hF;
    endtask

    task automatic test_two_rising;
        level = 4'b1010; evt_ready = 1'b1;
        cyc(1);
        tests++; if (evt_valid !== 1'b0) begin fails++; $display("FAIL two_rise_latency got %b exp 0", evt_valid); end
        cyc(1);
        tests++; if ({evt_valid, evt_ch, evt_rise} !== {1'b1, 2'd1, 1'b1})
            begin fails++; $display("FAIL two_rise_first got v%b ch%0d r%b exp v1 ch1 r1", evt_valid, evt_ch, evt_rise); end
        cyc(1);
        tests++; if (evt_valid !== 1'b0) begin fails++; $display("FAIL two_rise_gap got %b exp 0", evt_valid); end
        cyc(1);
        tests++; if ({evt_valid, evt_ch, evt_rise} !== {1'b1, 2'd3, 1'b1})
            begin fails++; $display("FAIL two_rise_second got v%b ch%0d r%b exp v1 ch3 r1", evt_valid, evt_ch, evt_rise); end
        cyc(1);
        tests++; if (evt_valid !== 1'b0) begin fails++; $display("FAIL two_rise_done got %b exp 0", evt_valid); end
        evt_ready = 1'b0;
    endtask

    task automatic test_pulse_ordering;
        level = 4'b1110;
        cyc(3);
        level = 4'b1010;
        cyc(7);
        tests++; if ({evt_valid, evt_ch, evt_rise} !== {1'b1, 2'd2, 1'b1})
            begin fails++; $display("FAIL pulse_rise got v%b ch%0d r%b exp v1 ch2 r1", evt_valid, evt_ch, evt_rise); end
        evt_ready = 1'b1;
        cyc(1);
        tests++; if (evt_valid !== 1'b0) begin fails++; $display("FAIL pulse_accept got %b exp 0", evt_valid); end
        cyc(1);
        tests++; if ({evt_valid, evt_ch, evt_rise} !== {1'b1, 2'd2, 1'b0})
            begin fails++; $display("FAIL pulse_fall got v%b ch%0d r%b exp v1 ch2 r0", evt_valid, evt_ch, evt_rise); end
        cyc(1);
        evt_ready = 1'b0;
        tests++; if (overrun !== 4'b0000) begin fails++; $display("FAIL pulse_overrun got %b exp 0000", overrun); end
    endtask

    task automatic test_overrun;
        level = 4'b1011; cyc(1);
        level = 4'b1010; cyc(1);
        level = 4'b1011; cyc(1);
        level = 4'b1010; cyc(1);
        cyc(2);
        tests++; if (overrun !== 4'b0001) begin fails++; $display("FAIL ovr_set got %b exp 0001", overrun); end
        tests++; if ({evt_valid, evt_ch, evt_rise} !== {1'b1, 2'd0, 1'b1})
            begin fails++; $display("FAIL ovr_rise got v%b ch%0d r%b exp v1 ch0 r1", evt_valid, evt_ch, evt_rise); end
        evt_ready = 1'b1;
        cyc(2);
        tests++; if ({evt_valid, evt_ch, evt_rise} !== {1'b1, 2'd0, 1'b0})
            begin fails++; $display("FAIL ovr_fall got v%b ch%0d r%b exp v1 ch0 r0", evt_valid, evt_ch, evt_rise); end
        for (int k = 0; k < 4; k++) begin
            cyc(1);
            tests++; if (evt_valid !== 1'b0) begin fails++; $display("FAIL ovr_drained cycle %0d got %b exp 0", k, evt_valid); end
        end
        evt_ready = 1'b0;
        tests++; if (overrun !== 4'b0001) begin fails++; $display("FAIL ovr_sticky got %b exp 0001", overrun); end
        clr_overrun = 1'b1; cyc(1); clr_overrun = 1'b0;
        cyc(1);
        tests++; if (overrun !== 4'b0000) begin fails++; $display("FAIL ovr_clear got %b exp 0000", overrun); end
    endtask

    task automatic test_enable_gating;
        fall_en = 4'b1101; level = 4'b1000; cyc(1);
        rise_en = 4'b1101; fall_en = 4'hF;
        level = 4'b1010; cyc(1);
        level = 4'b1000; cyc(1);
        evt_ready = 1'b1;
        cyc(1);
        tests++; if ({evt_valid, evt_ch, evt_rise} !== {1'b1, 2'd1, 1'b0})
            begin fails++; $display("FAIL gate_fall got v%b ch%0d r%b exp v1 ch1 r0", evt_valid, evt_ch, evt_rise); end
        cyc(1);
        cyc(1);
        tests++; if (evt_valid !== 1'b0) begin fails++; $display("FAIL gate_no_rise got %b exp 0", evt_valid); end
        evt_ready = 1'b0; rise_en = 4'hF;
    endtask

    task automatic test_back_to_back;
        level = 4'b1001; cyc(2);
        tests++; if ({evt_valid, evt_ch, evt_rise} !== {1'b1, 2'd0, 1'b1})
            begin fails++; $display("FAIL b2b_first got v%b ch%0d r%b exp v1 ch0 r1", evt_valid, evt_ch, evt_rise); end
        level = 4'b1000; cyc(1);
        level = 4'b1001; evt_ready = 1'b1; cyc(1);
        tests++; if (evt_valid !== 1'b0) begin fails++; $display("FAIL b2b_accept got %b exp 0", evt_valid); end
        tests++; if (overrun !== 4'b0000) begin fails++; $display("FAIL b2b_overrun got %b exp 0000", overrun); end
        cyc(1);
        tests++; if ({evt_valid, evt_ch, evt_rise} !== {1'b1, 2'd0, 1'b0})
            begin fails++; $display("FAIL b2b_fall got v%b ch%0d r%b exp v1 ch0 r0", evt_valid, evt_ch, evt_rise); end
        cyc(2);
        tests++; if ({evt_valid, evt_ch, evt_rise} !== {1'b1, 2'd0, 1'b1})
            begin fails++; $display("FAIL b2b_second_rise got v%b ch%0d r%b exp v1 ch0 r1", evt_valid, evt_ch, evt_rise); end
        cyc(1);
        evt_ready = 1'b0;
    endtask

    task automatic test_reset_in_offer;
        level = 4'b1111; cyc(1);
        level = 4'b0111; cyc(2);
        tests++; if ({evt_valid, evt_ch} !== {1'b1, 2'd1})
            begin fails++; $display("FAIL offer_before_reset got v%b ch%0d exp v1 ch1", evt_valid, evt_ch); end
        rst_n = 1'b0; level = 4'b0000; cyc(1);
        tests++; if (evt_valid !== 1'b0) begin fails++; $display("FAIL offer_reset_valid got %b exp 0", evt_valid); end
        tests++; if (overrun !== 4'b0000) begin fails++; $display("FAIL offer_reset_overrun got %b exp 0000", overrun); end
        rst_n = 1'b1; evt_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cyc(1);
            tests++; if (evt_valid !== 1'b0) begin fails++; $display("FAIL offer_stale cycle %0d got %b exp 0", k, evt_valid); end
        end
    endtask

    initial begin
        test_reset;
        test_two_rising;
        test_pulse_ordering;
        test_overrun;
        test_enable_gating;
        test_back_to_back;
        test_reset_in_offer;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
